// File: rtl/dac_playback_ctrl.sv
// dac_playback_ctrl: audio DAC playback scheduler.
// Prefills the sample FIFO to a programmable level, then pops one sample per
// programmable period into a registered DAC sample. Handles underrun
// (re-buffer or stop), graceful stop at frame end, and host status counters.
module dac_playback_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int LEVEL_WIDTH = 13,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   rate_div,
  input  logic [LEVEL_WIDTH-1:0] prefill_level,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  input  logic                   clear_stats,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  dac_sample,
  output logic                   sample_strobe,
  output logic [1:0]             state,
  output logic                   underrun,
  output logic [CNT_WIDTH-1:0]   underrun_count,
  output logic [CNT_WIDTH-1:0]   frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    PLAY    = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]  dac_q;
  logic                   strobe_q;
  logic                   und_q;
  logic [CNT_WIDTH-1:0]   ucnt_q, ucnt_d;
  logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d;

  logic running, tick, pop, und, pop_last;

  // The sample clock only exists while playing or draining; tready is the
  // raw tick so an async reset of state_q drops it immediately.
  assign running  = (state_q == PLAY) || (state_q == DRAIN);
  assign tick     = running && (cnt_q == '0);
  assign pop      = tick && s_axis_tvalid;
  assign und      = tick && !s_axis_tvalid;
  assign pop_last = pop && s_axis_tlast;

  assign s_axis_tready  = tick;
  assign dac_sample     = dac_q;
  assign sample_strobe  = strobe_q;
  assign underrun       = und_q;
  assign state          = state_q;
  assign underrun_count = ucnt_q;
  assign frame_count    = fcnt_q;

  // Playback state machine; underrun has priority over enable in PLAY/DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (enable) state_q <= PREFILL;
        PREFILL: begin
          if (!enable)                         state_q <= IDLE;
          else if (fifo_level >= prefill_level) state_q <= PLAY;
        end
        PLAY: begin
          if (und)          state_q <= PREFILL;
          else if (!enable) state_q <= DRAIN;
        end
        DRAIN: begin
          if (und || pop_last) state_q <= IDLE;
          else if (enable)     state_q <= PLAY;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Period down-counter: held at zero outside PLAY/DRAIN so PLAY entry ticks
  // at once; PLAY<->DRAIN leaves the phase untouched. rate_div is only
  // sampled on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (!running) cnt_q <= '0;
    else if (tick)    cnt_q <= rate_div;
    else              cnt_q <= cnt_q - 1'b1;
  end

  // Output sample register: new data on pop, midscale on underrun, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q    <= MIDSCALE;
      strobe_q <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      strobe_q <= tick;
      und_q    <= und;
      if (pop)      dac_q <= s_axis_tdata;
      else if (und) dac_q <= MIDSCALE;
    end
  end

  // Counter next-state: clear first, then count this cycle's event.
  always_comb begin
    ucnt_d = clear_stats ? '0 : ucnt_q;
    fcnt_d = clear_stats ? '0 : fcnt_q;
    if (und && (ucnt_d != '1)) ucnt_d = ucnt_d + 1'b1;
    if (pop_last)              fcnt_d = fcnt_d + 1'b1;
  end

  // Status counters: underruns saturate, frames wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
      fcnt_q <= fcnt_d;
    end
  end

endmodule

// File: doc/dac_playback_ctrl.md
# dac_playback_ctrl

Playback scheduler for the audio DAC path. Sits between the sample FIFO output (AXI-Stream master side) and the PDM modulator input, and owns the sample clock. It prefills the FIFO to a programmable level before starting, then pops exactly one sample per programmable sample period. It handles underruns and graceful stop-at-frame-end, and keeps status counters for the host.

## Interface

**Parameters**

- DATA_WIDTH, 8, sample width.
- DIV_WIDTH, 16, width of the sample-period divider.
- LEVEL_WIDTH, 13, width of the FIFO occupancy and prefill threshold.
- CNT_WIDTH, 16, width of the status counters.

**Ports**

- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high requests playback.
- rate_div  in  DIV_WIDTH  sample period minus 1, in clk cycles.
- prefill_level  in  LEVEL_WIDTH  FIFO occupancy required before play starts.
- fifo_level  in  LEVEL_WIDTH  current FIFO occupancy.
- clear_stats  in  1  pulse; clears both counters.
- s_axis_tdata  in  DATA_WIDTH  sample from FIFO.
- s_axis_tvalid  in  1  FIFO has data.
- s_axis_tlast  in  1  last sample of frame.
- s_axis_tready  out  1  pop strobe to FIFO.
- dac_sample  out  DATA_WIDTH  registered sample to modulator.
- sample_strobe  out  1  one-cycle pulse when dac_sample updates.
- state  out  2  IDLE=0, PREFILL=1, PLAY=2, DRAIN=3.
- underrun  out  1  one-cycle pulse per underrun.
- underrun_count  out  CNT_WIDTH  saturating underrun count.
- frame_count  out  CNT_WIDTH  wrapping count of consumed tlast samples.

## Operation

- Reset values: state=IDLE; dac_sample=midscale (1<<(DATA_WIDTH-1), 0x80 at default); sample_strobe=0; underrun=0; both counters 0; s_axis_tready=0; period counter 0.
- Period counter (down-counter) runs only in PLAY and DRAIN.
  - tick = (counter==0) in those states; on tick the counter reloads rate_div.
  - rate_div is sampled only at reload.
  - Entering PLAY from PREFILL forces counter=0, so the first tick is in the first PLAY cycle.
  - DRAIN↔PLAY transitions do not touch the counter.
- s_axis_tready = tick (combinational, state-qualified). Elsewhere 0.
- **Pop** = tick && tvalid.
  - Next cycle: dac_sample <= tdata and sample_strobe=1.
  - If tlast, frame_count increments (wraps).
- **Underrun** = tick && !tvalid.
  - Next cycle: dac_sample <= midscale, sample_strobe=1, underrun=1.
  - underrun_count increments, saturating at all-ones.
- clear_stats in the same cycle as an increment: the result is 1 (clear, then count the event).
- Transitions (evaluated each cycle; priority in listed order):
  - IDLE: enable -> PREFILL.
  - PREFILL: !enable -> IDLE; fifo_level >= prefill_level -> PLAY. prefill_level=0 means PLAY on the next cycle.
  - PLAY: underrun -> PREFILL (re-buffer); !enable -> DRAIN; otherwise stay.
  - DRAIN: underrun -> IDLE; pop with tlast -> IDLE; enable -> PLAY; otherwise stay, still popping one sample per period.
- dac_sample holds its last value in IDLE and PREFILL; it changes only on pop, underrun, or reset.

## Timing

- Steady-state pop interval is rate_div+1 cycles. rate_div=0 means a pop every cycle.
- Latency:
  - pop -> dac_sample/sample_strobe: 1 cycle.
  - PREFILL threshold met -> first pop: 1 cycle (the PLAY entry cycle).
  - enable falling -> DRAIN: 1 cycle.
  - DRAIN tlast pop -> IDLE: 1 cycle, with that sample presented.
- Tick is evaluated in the state's cycle. A tick in the cycle enable falls still pops, because the state is still PLAY.
- rst_n assertion mid-operation: all outputs go immediately to reset values. s_axis_tready drops asynchronously and no partial pop occurs.
- A change of rate_div mid-period takes effect after the current period.

## Test plan

- Reset, then enable=1, prefill_level=4, rate_div=3; load FIFO with 0x10..0x17 (level rises 0..8).
  - Expect PLAY the cycle after level reaches 4, tready pulses every 4 cycles, and dac_sample sequence 0x10,0x11,…, each with a strobe 1 cycle after its pop.
- Starve the FIFO during PLAY.
  - Expect one underrun pulse, dac_sample=0x80, underrun_count=1, state=PREFILL, and no pops until the level reaches prefill_level again.
- In PLAY, drop enable with a frame whose tlast is on its 3rd remaining sample.
  - Expect DRAIN, exactly 3 more pops at the same period, frame_count+1, then IDLE with dac_sample holding the tlast value.
- In DRAIN, re-assert enable before tlast.
  - Expect return to PLAY with no gap or phase shift in the pop cadence.
- Force 0xFFFF underruns (CNT_WIDTH=16), then one more.
  - Expect the count to stay 0xFFFF.
  - clear_stats coincident with an underrun gives count 1.
- Assert rst_n low mid-period in PLAY.
  - Expect immediate tready=0, state=IDLE, dac_sample=0x80, and counters 0.
